// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifq_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with single-cycle flush.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  ifq_entry_t    push_entry,
    input  logic          pop,
    output logic [CW-1:0] count,
    output ifq_entry_t    head,
    output logic          head_valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ifq_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem_q[wr_ptr_q] <= push_entry;
    end

    assign count      = count_q;
    assign head       = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between IF stage and an in-order memory port.
// Optional same-cycle response bypass enabled by defining IFQ_BYPASS_EN.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    input  logic        stallF,
    input  logic        redirect,
    input  logic [31:0] redirectpc,
    output logic [31:0] instrF,
    output logic        instrvalid,
    output logic        fetchstall,
    output logic        imemreq,
    output logic [31:0] imemaddr,
    input  logic        imemgnt,
    input  logic        imemrvalid,
    input  logic [31:0] imemrdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    logic [31:0]   fetchpc_q, fetchpc_d;
    logic [31:0]   resppc_q, resppc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0] count;
    ifq_entry_t    head;
    logic          head_valid;
    logic          head_match;
    logic          mismatch;
    logic          flush;
    logic          grant;
    logic          bypass_hit;
    logic          push;
    logic          pop;
    ifq_entry_t    push_entry;
    logic [CW:0]   inflight;

    ifq_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .head       (head),
        .head_valid (head_valid)
    );

    assign head_match = head_valid && (head.pc == pcF);
    assign mismatch   = head_valid && (head.pc != pcF) && !redirect;
    assign flush      = redirect || mismatch;
    assign inflight   = {1'b0, count} + {1'b0, outst_q};

    assign imemreq  = !reset && !flush && (inflight < LIMIT);
    assign imemaddr = {fetchpc_q[31:2], 2'b00};
    assign grant    = imemreq && imemgnt;

`ifdef IFQ_BYPASS_EN
    assign bypass_hit = !head_valid && imemrvalid && (drop_q == '0) && (resppc_q == pcF);
    assign instrvalid = head_match || bypass_hit;
    assign instrF     = head_match ? head.instr : (bypass_hit ? imemrdata : NOP_INSTR);
`else
    assign bypass_hit = 1'b0;
    assign instrvalid = head_match;
    assign instrF     = head_match ? head.instr : NOP_INSTR;
`endif

    assign fetchstall = !instrvalid;
    assign push_entry = '{pc: resppc_q, instr: imemrdata};

    always_comb begin
        fetchpc_d = fetchpc_q;
        resppc_d  = resppc_q;
        outst_d   = outst_q;
        drop_d    = drop_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (flush) begin
            // Everything still in flight belongs to the abandoned path.
            fetchpc_d = redirect ? redirectpc : pcF;
            resppc_d  = redirect ? redirectpc : pcF;
            outst_d   = outst_q - CW'(imemrvalid);
            drop_d    = outst_q - CW'(imemrvalid);
        end else begin
            if (grant) fetchpc_d = next_word(fetchpc_q);
            if (imemrvalid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    resppc_d = next_word(resppc_q);
                    push     = !(bypass_hit && !stallF);
                end
            end
            pop     = head_match && !stallF;
            outst_d = outst_q + CW'(grant) - CW'(imemrvalid);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchpc_q <= RESET_PC;
            resppc_q  <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
        end else begin
            fetchpc_q <= fetchpc_d;
            resppc_q  <= resppc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (default build, DEPTH=4, RESET_PC=0).
module tb_ifetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pcF = '0;
    logic        stallF = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectpc = '0;
    logic [31:0] instrF;
    logic        instrvalid;
    logic        fetchstall;
    logic        imemreq;
    logic [31:0] imemaddr;
    logic        imemgnt = 1'b0;
    logic        imemrvalid = 1'b0;
    logic [31:0] imemrdata = '0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] pend[$];

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pcF        (pcF),
        .stallF     (stallF),
        .redirect   (redirect),
        .redirectpc (redirectpc),
        .instrF     (instrF),
        .instrvalid (instrvalid),
        .fetchstall (fetchstall),
        .imemreq    (imemreq),
        .imemaddr   (imemaddr),
        .imemgnt    (imemgnt),
        .imemrvalid (imemrvalid),
        .imemrdata  (imemrdata)
    );

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, model an in-order memory returning D(addr).
    task automatic step(input logic g, input logic r, input logic st,
                        input logic [31:0] pc, input logic rd, input logic [31:0] rpc);
        @(posedge clk); #1;
        reset      = 1'b0;
        imemgnt    = g;
        stallF     = st;
        pcF        = pc;
        redirect   = rd;
        redirectpc = rpc;
        if (r && pend.size() > 0) begin
            imemrvalid = 1'b1;
            imemrdata  = dat(pend.pop_front());
        end else begin
            imemrvalid = 1'b0;
            imemrdata  = '0;
        end
        #1;
        if (imemreq === 1'b1 && imemgnt) pend.push_back(imemaddr);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        imemgnt    = 1'b0;
        imemrvalid = 1'b0;
        redirect   = 1'b0;
        stallF     = 1'b0;
        pend.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_req", imemreq, 1'b0);
        chk("rst_valid", instrvalid, 1'b0);
        chk("rst_fstall", fetchstall, 1'b1);
        chk("rst_instr", instrF, NOP);

        // Zero-wait memory streaming
        step(1, 1, 0, 32'h0, 0, 0);
        chk("zw_c1_req", imemreq, 1'b1);
        chk("zw_c1_addr", imemaddr, 32'h0);
        step(1, 1, 0, 32'h0, 0, 0);
        chk("zw_c2_addr", imemaddr, 32'h4);
        chk("zw_c2_valid", instrvalid, 1'b0);
        step(1, 1, 0, 32'h0, 0, 0);
        chk("zw_c3_addr", imemaddr, 32'h8);
        chk("zw_c3_valid", instrvalid, 1'b1);
        chk("zw_c3_instr", instrF, dat(32'h0));
        step(1, 1, 0, 32'h4, 0, 0);
        chk("zw_c4_instr", instrF, dat(32'h4));
        chk("zw_c4_fstall", fetchstall, 1'b0);
        step(1, 1, 0, 32'h8, 0, 0);
        chk("zw_c5_instr", instrF, dat(32'h8));
        chk("zw_c5_valid", instrvalid, 1'b1);

        // Credit limit with responses withheld
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 32'h0, 0, 0);
            chk("cr_grant_addr", imemaddr, 32'(i * 4));
        end
        step(1, 0, 0, 32'h0, 0, 0);
        chk("cr_c5_req", imemreq, 1'b0);
        step(1, 0, 0, 32'h0, 0, 0);
        chk("cr_c6_req", imemreq, 1'b0);
        chk("cr_grants", 32'(pend.size()), 32'd4);
        step(1, 1, 0, 32'h0, 0, 0);
        chk("cr_c7_req", imemreq, 1'b0);
        step(1, 0, 0, 32'h0, 0, 0);
        chk("cr_c8_valid", instrvalid, 1'b1);
        chk("cr_c8_instr", instrF, dat(32'h0));
        chk("cr_c8_req", imemreq, 1'b0);
        step(0, 0, 0, 32'h4, 0, 0);
        chk("cr_c9_req", imemreq, 1'b1);
        chk("cr_c9_addr", imemaddr, 32'h10);

        // Redirect with two requests outstanding
        do_reset();
        step(1, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 1, 32'h100);
        chk("rd_req_during", imemreq, 1'b0);
        step(1, 1, 0, 32'h100, 0, 0);
        chk("rd_addr", imemaddr, 32'h100);
        chk("rd_valid_a", instrvalid, 1'b0);
        step(0, 1, 0, 32'h100, 0, 0);
        chk("rd_valid_b", instrvalid, 1'b0);
        step(0, 1, 0, 32'h100, 0, 0);
        chk("rd_valid_c", instrvalid, 1'b0);
        step(0, 0, 0, 32'h100, 0, 0);
        chk("rd_first_valid", instrvalid, 1'b1);
        chk("rd_first_instr", instrF, dat(32'h100));

        // Stall with a full queue, then release
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 1, 32'h0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 32'h0, 0, 0);
            chk("st_req", imemreq, 1'b0);
            chk("st_valid", instrvalid, 1'b1);
            chk("st_instr", instrF, dat(32'h0));
        end
        step(1, 1, 0, 32'h0, 0, 0);
        chk("st_rel0", instrF, dat(32'h0));
        step(1, 1, 0, 32'h4, 0, 0);
        chk("st_rel1", instrF, dat(32'h4));
        chk("st_rel1_addr", imemaddr, 32'h10);
        step(1, 1, 0, 32'h8, 0, 0);
        chk("st_rel2", instrF, dat(32'h8));
        step(1, 1, 0, 32'hC, 0, 0);
        chk("st_rel3", instrF, dat(32'hC));
        chk("st_rel3_valid", instrvalid, 1'b1);

        // Head pc differs from pcF
        do_reset();
        step(0, 0, 0, 32'h0, 1, 32'h8);
        step(1, 0, 0, 32'h20, 0, 0);
        chk("mm_req_addr", imemaddr, 32'h8);
        step(0, 1, 0, 32'h20, 0, 0);
        chk("mm_empty_valid", instrvalid, 1'b0);
        step(0, 0, 0, 32'h20, 0, 0);
        chk("mm_fstall", fetchstall, 1'b1);
        chk("mm_req_blocked", imemreq, 1'b0);
        step(0, 0, 0, 32'h20, 0, 0);
        chk("mm_new_req", imemreq, 1'b1);
        chk("mm_new_addr", imemaddr, 32'h20);

        // Reset mid-operation with entries queued and a request outstanding
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 1, 32'h0, 0, 0);
        do_reset();
        chk("mr_req", imemreq, 1'b0);
        chk("mr_addr", imemaddr, 32'h0);
        chk("mr_fstall", fetchstall, 1'b1);
        chk("mr_instr", instrF, NOP);
        step(0, 1, 0, 32'h0, 0, 0);
        chk("mr_after_valid", instrvalid, 1'b0);
        chk("mr_after_req", imemreq, 1'b1);
        chk("mr_after_addr", imemaddr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
